// File: rtl/adc0804_sampler.sv
// rtl/adc0804_sampler.sv - ADC0804 conversion sequencer and 8-bit sample register
//
// Purpose:
//   Starts an ADC0804 conversion every SAMPLE_PERIOD clocks, waits for INTR_n,
//   reads DB[7:0] and presents the result as a registered sample with a
//   one-cycle valid strobe. A conversion that never signals INTR_n within
//   CONV_TIMEOUT clocks is abandoned and flagged.
//
// Configuration macro:
//   ADC_AVG4_EN - when defined, four captures are summed and their truncated
//                 mean is reported once per four conversions.
//
// Ports:
//   clk            in   1  system clock (2.08 MHz oscillator)
//   reset          in   1  synchronous, active-high reset
//   intr_n_i       in   1  ADC INTR_n, asynchronous, active-low
//   db_i           in   8  ADC data bus
//   cs_n_o         out  1  ADC chip select, active-low
//   wr_n_o         out  1  ADC write/start, active-low
//   rd_n_o         out  1  ADC read/output enable, active-low
//   sample_o       out  8  last accepted conversion result
//   sample_valid_o out  1  one-cycle strobe, sample_o updated this cycle
//   timeout_o      out  1  one-cycle strobe, conversion aborted
//   fault_o        out  1  sticky timeout flag, cleared by next valid sample
`timescale 1ns/1ps
module adc0804_sampler #(
   parameter int SAMPLE_PERIOD = 2080,
   parameter int WR_CYCLES     = 2,
   parameter int RD_CYCLES     = 2,
   parameter int CONV_TIMEOUT  = 512
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       intr_n_i,
   input  logic [7:0] db_i,
   output logic       cs_n_o,
   output logic       wr_n_o,
   output logic       rd_n_o,
   output logic [7:0] sample_o,
   output logic       sample_valid_o,
   output logic       timeout_o,
   output logic       fault_o
);

   // Period counter width and a single shared phase timer wide enough for
   // the longest of the WR, WAIT and RD phases.
   localparam int PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int TW = $clog2(CONV_TIMEOUT + WR_CYCLES + RD_CYCLES + 4);

   localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [TW-1:0] WR_LAST     = TW'(WR_CYCLES - 1);
   localparam logic [TW-1:0] RD_LAST     = TW'(RD_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST     = TW'(CONV_TIMEOUT - 1);
   // INTR_n is only trusted once the synchronizer has flushed whatever it
   // held from before this conversion started.
   localparam logic [TW-1:0] BLANK_CYC   = TW'(2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WAIT,
      S_RD,
      S_DONE
   } state_t;

   // ---------------------------------------------------------------
   // Free-running sample period counter
   // ---------------------------------------------------------------
   logic [PW-1:0] period_cnt;
   logic          tick;

   assign tick = (period_cnt == PERIOD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         period_cnt <= '0;
      end else if (tick) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // INTR_n synchronizer, idles high so reset never looks like INTR
   // ---------------------------------------------------------------
   logic intr_meta;
   logic intr_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         intr_meta <= 1'b1;
         intr_sync <= 1'b1;
      end else begin
         intr_meta <= intr_n_i;
         intr_sync <= intr_meta;
      end
   end

   // ---------------------------------------------------------------
   // Handshake FSM: all outputs are registered next-state values so
   // the ADC strobes change on the same edge as the state.
   // ---------------------------------------------------------------
   state_t        state_q,   state_d;
   logic [TW-1:0] tmr_q,     tmr_d;
   logic          cs_n_q,    cs_n_d;
   logic          wr_n_q,    wr_n_d;
   logic          rd_n_q,    rd_n_d;
   logic [7:0]    cap_q,     cap_d;
   logic [7:0]    sample_q,  sample_d;
   logic          valid_q,   valid_d;
   logic          timeout_q, timeout_d;
   logic          fault_q,   fault_d;

`ifdef ADC_AVG4_EN
   logic [9:0]    acc_q,     acc_d;
   logic [1:0]    avg_cnt_q, avg_cnt_d;
   logic [9:0]    avg_sum;
`endif

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      cs_n_d    = 1'b1;
      wr_n_d    = 1'b1;
      rd_n_d    = 1'b1;
      cap_d     = cap_q;
      sample_d  = sample_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      fault_d   = fault_q;
`ifdef ADC_AVG4_EN
      acc_d     = acc_q;
      avg_cnt_d = avg_cnt_q;
      // Four 8-bit captures sum to at most 1020, so 10 bits never overflow.
      avg_sum   = acc_q + {2'b00, cap_q};
`endif

      case (state_q)
         S_IDLE: begin
            // Ticks seen in any other state are simply lost.
            if (tick) begin
               state_d = S_WR;
               tmr_d   = '0;
               cs_n_d  = 1'b0;
               wr_n_d  = 1'b0;
            end
         end

         S_WR: begin
            if (tmr_q == WR_LAST) begin
               state_d = S_WAIT;
               tmr_d   = '0;
            end else begin
               tmr_d   = tmr_q + 1'b1;
               cs_n_d  = 1'b0;
               wr_n_d  = 1'b0;
            end
         end

         S_WAIT: begin
            // INTR is checked before the timeout so a late INTR still wins.
            if ((tmr_q >= BLANK_CYC) && !intr_sync) begin
               state_d = S_RD;
               tmr_d   = '0;
               cs_n_d  = 1'b0;
               rd_n_d  = 1'b0;
            end else if (tmr_q == TO_LAST) begin
               state_d   = S_IDLE;
               tmr_d     = '0;
               timeout_d = 1'b1;
               fault_d   = 1'b1;
`ifdef ADC_AVG4_EN
               acc_d     = '0;
               avg_cnt_d = '0;
`endif
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         S_RD: begin
            if (tmr_q == RD_LAST) begin
               // Bus is sampled while RD_n is still low, then released.
               cap_d   = db_i;
               state_d = S_DONE;
               tmr_d   = '0;
            end else begin
               tmr_d  = tmr_q + 1'b1;
               cs_n_d = 1'b0;
               rd_n_d = 1'b0;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
`ifdef ADC_AVG4_EN
            if (avg_cnt_q == 2'd3) begin
               sample_d  = avg_sum[9:2];
               valid_d   = 1'b1;
               fault_d   = 1'b0;
               acc_d     = '0;
               avg_cnt_d = '0;
            end else begin
               acc_d     = avg_sum;
               avg_cnt_d = avg_cnt_q + 1'b1;
            end
`else
            sample_d = cap_q;
            valid_d  = 1'b1;
            fault_d  = 1'b0;
`endif
         end

         default: begin
            state_d = S_IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         tmr_q     <= '0;
         cs_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         cap_q     <= '0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         fault_q   <= 1'b0;
`ifdef ADC_AVG4_EN
         acc_q     <= '0;
         avg_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         cs_n_q    <= cs_n_d;
         wr_n_q    <= wr_n_d;
         rd_n_q    <= rd_n_d;
         cap_q     <= cap_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         fault_q   <= fault_d;
`ifdef ADC_AVG4_EN
         acc_q     <= acc_d;
         avg_cnt_q <= avg_cnt_d;
`endif
      end
   end

   assign cs_n_o         = cs_n_q;
   assign wr_n_o         = wr_n_q;
   assign rd_n_o         = rd_n_q;
   assign sample_o       = sample_q;
   assign sample_valid_o = valid_q;
   assign timeout_o      = timeout_q;
   assign fault_o        = fault_q;

endmodule

// File: tb/tb_adc0804_sampler.sv
// tb/tb_adc0804_sampler.sv - directed self-checking bench for adc0804_sampler
`timescale 1ns/1ps
module tb_adc0804_sampler;

   localparam int SIG_WR     = 0;
   localparam int SIG_RD     = 1;
   localparam int SIG_VALID  = 2;
   localparam int SIG_WR2    = 3;
   localparam int SIG_RD2    = 4;
   localparam int SIG_VALID2 = 5;
   localparam int SIG_TO2    = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       intr_n,  intr_n2;
   logic [7:0] db,      db2;
   logic       cs_n,    cs_n2;
   logic       wr_n,    wr_n2;
   logic       rd_n,    rd_n2;
   logic [7:0] sample,  sample2;
   logic       valid,   valid2;
   logic       timeout, timeout2;
   logic       fault,   fault2;

   int checks      = 0;
   int errors      = 0;
   int cyc         = 0;
   int valid_cnt   = 0;
   int overlap_cnt = 0;
   int cs_bad_cnt  = 0;

   always #5 clk = ~clk;

   adc0804_sampler #(
      .SAMPLE_PERIOD(64), .WR_CYCLES(2), .RD_CYCLES(2), .CONV_TIMEOUT(512)
   ) u_dut (
      .clk(clk), .reset(reset), .intr_n_i(intr_n), .db_i(db),
      .cs_n_o(cs_n), .wr_n_o(wr_n), .rd_n_o(rd_n), .sample_o(sample),
      .sample_valid_o(valid), .timeout_o(timeout), .fault_o(fault)
   );

   adc0804_sampler #(
      .SAMPLE_PERIOD(64), .WR_CYCLES(2), .RD_CYCLES(2), .CONV_TIMEOUT(32)
   ) u_dut_to (
      .clk(clk), .reset(reset), .intr_n_i(intr_n2), .db_i(db2),
      .cs_n_o(cs_n2), .wr_n_o(wr_n2), .rd_n_o(rd_n2), .sample_o(sample2),
      .sample_valid_o(valid2), .timeout_o(timeout2), .fault_o(fault2)
   );

   // Cycle index since reset release; equals the DUT period count modulo 64.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (valid === 1'b1) valid_cnt++;
      if ((wr_n === 1'b0 && rd_n === 1'b0) || (wr_n2 === 1'b0 && rd_n2 === 1'b0))
         overlap_cnt++;
      if ((wr_n === 1'b1 && rd_n === 1'b1 && cs_n !== 1'b1) ||
          (wr_n2 === 1'b1 && rd_n2 === 1'b1 && cs_n2 !== 1'b1))
         cs_bad_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         SIG_WR:     return wr_n;
         SIG_RD:     return rd_n;
         SIG_VALID:  return valid;
         SIG_WR2:    return wr_n2;
         SIG_RD2:    return rd_n2;
         SIG_VALID2: return valid2;
         SIG_TO2:    return timeout2;
         default:    return 1'bx;
      endcase
   endfunction

   // Returns the number of negedges until the signal shows val, or -1.
   task automatic wait_for(input int which, input logic val, input int budget, output int n);
      n = 0;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (sig(which) === val) return;
      end
      n = -1;
   endtask

   // One full conversion on u_dut; the ADC drops INTR_n 'delay' cycles
   // after WR_n rises and presents 'data' on the bus.
   task automatic do_conv(input string name, input int delay, input logic [7:0] data,
                          input bit exp_valid, input logic [7:0] exp_sample,
                          output int wr_cyc);
      int n;
      wait_for(SIG_WR, 1'b0, 200, n);
      chk({name, ":wr_start"}, 32'(n != -1), 32'd1);
      wr_cyc = cyc;
      chk({name, ":wr_phase"}, 32'(cyc % 64), 32'd0);
      chk({name, ":cs_in_wr"}, 32'(cs_n), 32'd0);
      chk({name, ":rd_in_wr"}, 32'(rd_n), 32'd1);
      wait_for(SIG_WR, 1'b1, 10, n);
      chk({name, ":wr_width"}, n, 32'd2);
      repeat (delay) @(negedge clk);
      intr_n = 1'b0;
      db     = data;
      wait_for(SIG_RD, 1'b0, 10, n);
      chk({name, ":rd_latency"}, n, 32'd3);
      intr_n = 1'b1;
      wait_for(SIG_RD, 1'b1, 10, n);
      chk({name, ":rd_width"}, n, 32'd2);
      db = ~data;
      wait_for(SIG_VALID, 1'b1, 3, n);
      chk({name, ":valid_latency"}, n, exp_valid ? 32'd1 : 32'hFFFF_FFFF);
      chk({name, ":sample"}, 32'(sample), 32'(exp_sample));
      @(negedge clk);
      chk({name, ":valid_single"}, 32'(valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int w0;
      int w1;
      int vbase;

      reset   = 1'b1;
      intr_n  = 1'b1;
      intr_n2 = 1'b1;
      db      = 8'h00;
      db2     = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst:cs_n", 32'(cs_n), 32'd1);
      chk("rst:wr_n", 32'(wr_n), 32'd1);
      chk("rst:rd_n", 32'(rd_n), 32'd1);
      chk("rst:sample", 32'(sample), 32'd0);
      chk("rst:valid", 32'(valid), 32'd0);
      chk("rst:timeout", 32'(timeout), 32'd0);
      chk("rst:fault", 32'(fault), 32'd0);
      chk("rst:fault2", 32'(fault2), 32'd0);
      reset = 1'b0;

`ifdef ADC_AVG4_EN
      do_conv("avg1", 20, 8'd10, 1'b0, 8'd0, w0);
      chk("avg1:fault", 32'(fault), 32'd0);
      do_conv("avg2", 20, 8'd11, 1'b0, 8'd0, w0);
      do_conv("avg3", 20, 8'd12, 1'b0, 8'd0, w0);
      do_conv("avg4", 20, 8'd14, 1'b1, 8'd11, w0);
      chk("avg:valid_count", valid_cnt, 32'd1);
`else
      // Timeout on the short-timeout instance, then recovery.
      wait_for(SIG_WR2, 1'b0, 100, n);
      chk("to:wr_start", n, 32'd64);
      wait_for(SIG_WR2, 1'b1, 10, n);
      chk("to:wr_width", n, 32'd2);
      wait_for(SIG_TO2, 1'b1, 40, n);
      chk("to:timeout_latency", n, 32'd32);
      chk("to:fault_set", 32'(fault2), 32'd1);
      chk("to:sample_kept", 32'(sample2), 32'd0);
      @(negedge clk);
      chk("to:timeout_single", 32'(timeout2), 32'd0);
      chk("to:fault_sticky", 32'(fault2), 32'd1);
      wait_for(SIG_WR2, 1'b0, 100, n);
      chk("to:next_wr_cyc", cyc, 32'd128);
      wait_for(SIG_WR2, 1'b1, 10, n);
      repeat (5) @(negedge clk);
      intr_n2 = 1'b0;
      db2     = 8'h10;
      wait_for(SIG_RD2, 1'b0, 10, n);
      chk("to:rd_latency", n, 32'd3);
      intr_n2 = 1'b1;
      wait_for(SIG_RD2, 1'b1, 10, n);
      chk("to:fault_before_valid", 32'(fault2), 32'd1);
      wait_for(SIG_VALID2, 1'b1, 3, n);
      chk("to:valid_latency", n, 32'd1);
      chk("to:sample", 32'(sample2), 32'h10);
      chk("to:fault_cleared", 32'(fault2), 32'd0);

      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Nominal conversion.
      do_conv("nom", 50, 8'hA5, 1'b1, 8'hA5, w0);
      chk("nom:first_wr_cyc", w0, 32'd64);
      chk("nom:fault", 32'(fault), 32'd0);
      chk("nom:valid_count", valid_cnt, 32'd1);

      // INTR_n stuck low from before WR: RD only after blanking.
      intr_n = 1'b0;
      db     = 8'h5A;
      wait_for(SIG_WR, 1'b0, 200, n);
      chk("stuck:wr_cyc", cyc, 32'd128);
      chk("stuck:no_rd_before_wr", 32'(rd_n), 32'd1);
      wait_for(SIG_WR, 1'b1, 10, n);
      chk("stuck:wr_width", n, 32'd2);
      wait_for(SIG_RD, 1'b0, 10, n);
      chk("stuck:rd_after_blank", n, 32'd3);
      intr_n = 1'b1;
      wait_for(SIG_RD, 1'b1, 10, n);
      chk("stuck:rd_width", n, 32'd2);
      wait_for(SIG_VALID, 1'b1, 3, n);
      chk("stuck:valid_latency", n, 32'd1);
      chk("stuck:sample", 32'(sample), 32'h5A);

      // Stale INTR_n released at WAIT entry: must not trigger RD.
      intr_n = 1'b0;
      db     = 8'hC3;
      wait_for(SIG_WR, 1'b0, 200, n);
      wait_for(SIG_WR, 1'b1, 10, n);
      intr_n = 1'b1;
      wait_for(SIG_RD, 1'b0, 10, n);
      chk("stale:no_rd", n, 32'hFFFF_FFFF);
      intr_n = 1'b0;
      wait_for(SIG_RD, 1'b0, 10, n);
      chk("stale:rd_latency", n, 32'd3);
      intr_n = 1'b1;
      wait_for(SIG_RD, 1'b1, 10, n);
      wait_for(SIG_VALID, 1'b1, 3, n);
      chk("stale:valid_latency", n, 32'd1);
      chk("stale:sample", 32'(sample), 32'hC3);

      // Long conversion: the tick falling in WAIT is dropped.
      do_conv("drop", 70, 8'h7E, 1'b1, 8'h7E, w0);
      vbase = valid_cnt;
      wait_for(SIG_WR, 1'b0, 200, n);
      w1 = cyc;
      chk("drop:wr_spacing", 32'(w1 - w0), 32'd128);

      // Reset during the first RD cycle.
      wait_for(SIG_WR, 1'b1, 10, n);
      repeat (10) @(negedge clk);
      intr_n = 1'b0;
      db     = 8'h99;
      wait_for(SIG_RD, 1'b0, 10, n);
      chk("rstrd:rd_latency", n, 32'd3);
      reset  = 1'b1;
      intr_n = 1'b1;
      @(negedge clk);
      chk("rstrd:cs_n", 32'(cs_n), 32'd1);
      chk("rstrd:rd_n", 32'(rd_n), 32'd1);
      chk("rstrd:sample", 32'(sample), 32'd0);
      chk("rstrd:valid", 32'(valid), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstrd:no_valid", valid_cnt, vbase);

      // Direct capture of a sequence of samples after reset.
      do_conv("s10", 20, 8'd10, 1'b1, 8'd10, w0);
      chk("rstrd:restart_cyc", w0, 32'd64);
      do_conv("s11", 20, 8'd11, 1'b1, 8'd11, w0);
      do_conv("s12", 20, 8'd12, 1'b1, 8'd12, w0);
      do_conv("s14", 20, 8'd14, 1'b1, 8'd14, w0);
      repeat (5) @(negedge clk);
      chk("hold:sample", 32'(sample), 32'd14);
      chk("seq:valid_count", valid_cnt, 32'(vbase + 4));
`endif

      chk("mon:wr_rd_overlap", overlap_cnt, 32'd0);
      chk("mon:cs_idle_high", cs_bad_cnt, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc0804_sampler.md
Name: adc0804_sampler

Overview:
- Upstream stage of the voltmeter datapath; owns the complete ADC0804 read handshake: CS_n/WR_n/RD_n drive, INTR_n wait, DB[7:0] capture.
- Runs periodic conversions on the 2.08 MHz oscillator clock.
- Presents each result as a registered 8-bit sample with a one-cycle valid strobe.
- The sample feeds the BCD/digit path as its 8-bit input.

Parameters:
- SAMPLE_PERIOD, 2080: cycles between conversion start requests (1 ms at 2.08 MHz); must be ≥ 16.
- WR_CYCLES, 2: cycles WR_n/CS_n held low to start a conversion; must be ≥ 1.
- RD_CYCLES, 2: cycles RD_n/CS_n held low before data capture (covers tACC); must be ≥ 1.
- CONV_TIMEOUT, 512: max cycles in WAIT before abort (nominal conversion ≈ 208 cycles).

Ports:
- clk  in  1  system clock, 2.08 MHz oscillator.
- reset  in  1  synchronous, active-high reset.
- intr_n_i  in  1  ADC0804 INTR_n; asynchronous, active-low.
- db_i  in  8  ADC0804 data bus.
- cs_n_o  out  1  ADC chip select, active-low.
- wr_n_o  out  1  ADC write/start, active-low.
- rd_n_o  out  1  ADC read/output enable, active-low.
- sample_o  out  8  last accepted conversion result.
- sample_valid_o  out  1  one-cycle strobe; sample_o updated this cycle.
- timeout_o  out  1  one-cycle strobe; conversion aborted.
- fault_o  out  1  sticky; set on timeout, cleared on next sample_valid_o.

Behaviour:
- Reset (sync, active-high, all registers):
  - cs_n_o=1, wr_n_o=1, rd_n_o=1, sample_o=0, sample_valid_o=0, timeout_o=0, fault_o=0.
  - FSM=IDLE, period counter=0, synchronizer flops=1.
  - Reset asserted mid-handshake deasserts CS/WR/RD on that same edge; any partial sample is discarded.
- intr_n_i passes through a 2-flop synchronizer (reset value 1); only intr_sync is used.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1, then wraps to 0.
  - tick asserts for one cycle when count == SAMPLE_PERIOD-1.
  - A tick arriving while the FSM is not in IDLE is dropped, not queued.
- FSM, with outputs registered and changing on the transition edge:
  - IDLE: CS/WR/RD all high. On tick, go to WR.
  - WR: cs_n=0, wr_n=0 for exactly WR_CYCLES cycles, then go to WAIT.
  - WAIT: CS/WR/RD high. Wait timer starts at 0.
    - intr_sync is ignored for the first 2 WAIT cycles (synchronizer blanking).
    - After blanking, intr_sync==0 moves to RD.
    - If the timer reaches CONV_TIMEOUT-1 with no INTR: go to IDLE, pulse timeout_o, set fault_o.
    - If INTR and timeout occur in the same cycle, INTR wins.
  - RD: cs_n=0, rd_n=0 for exactly RD_CYCLES cycles. db_i is captured on the clock edge ending the last RD cycle; that same edge raises CS/RD and moves to DONE.
  - DONE: one cycle. sample_o and sample_valid_o update here (or as defined in the optional feature); fault_o clears on valid; go to IDLE.
- Latency: tick to WR_n low is 1 cycle; RD_n rising to sample_valid_o is 1 cycle.
- WR_n and RD_n are never low simultaneously; CS_n is high whenever both are high.
- sample_o holds its value between valid strobes.

Optional Feature:
- Macro: ADC_AVG4_EN.
- Defined:
  - Each capture adds db_i into a 10-bit accumulator and increments a 2-bit count.
  - On the 4th capture: sample_o = (acc + db_i) >> 2 (truncating); sample_valid_o pulses; acc and count clear.
  - On the first 3 captures, DONE updates acc/count only; no valid, fault_o unchanged.
  - A timeout clears acc and count.
  - Reset clears both.
- Undefined: every capture updates sample_o directly with a valid pulse; no accumulator is synthesized.

Test Plan:
- Nominal read, SAMPLE_PERIOD=64, WR_CYCLES=2, RD_CYCLES=2. ADC model drops INTR_n 50 cycles after WR_n rises, db=8'hA5 → WR_n low exactly 2 cycles, RD_n low exactly 2 cycles, sample_o=A5, single sample_valid_o pulse, fault_o=0.
- Timeout, CONV_TIMEOUT=32, INTR_n held high → timeout_o pulses 32 cycles after WAIT entry. Then fault_o=1 and sample_o unchanged. Next good conversion (db=8'h10) → fault_o=0 on valid.
- Stale INTR, INTR_n stuck low from the previous conversion → first 2 WAIT cycles ignored. RD starts only if INTR_n is still low after blanking; no RD without a preceding WR.
- Reset mid-RD, reset asserted in the first RD cycle → CS/RD high next edge, sample_o=0, no valid. Next conversion starts at count 63 after release.
- Dropped tick, ADC INTR delay 70 cycles with SAMPLE_PERIOD=64 → tick during WAIT ignored. Exactly one conversion per completed handshake; no back-to-back WR.
- ADC_AVG4_EN defined, samples 10, 11, 12, 14 → single valid after the 4th with sample_o=8'd11. No valid on captures 1–3.
